game_link_tx: RTL and testbench

GAME_LINK_TX -- requirements
Module: game_link_tx

---
 rtl/game_link_tx.sv | 180 ++++++++++++++++++
 tb/tb_game_link_tx.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_link_tx.sv
// -----------------------------------------------------------------------------
// game_link_tx
//
// Purpose:
//   Sends the local game status to the remote board as a short byte frame over
//   a valid/ready byte interface (normally a UART transmitter). A frame is sent
//   when any status input changes with respect to the last frame sent, and
//   every REFRESH_CYCLES clock cycles even when nothing changes.
//
//   Frame layout:
//     byte0 : 0xA5 header
//     byte1 : {1'b0, game_state[1:0], game_start, current_health[3:0]}
//     byte2 : {1'b0, boss_hp[6:0]}
//     byte3 : byte0 ^ byte1 ^ byte2   (only when GAME_LINK_CHKSUM_EN is defined)
//
// Build option:
//   GAME_LINK_CHKSUM_EN  - when defined, every frame carries the checksum
//                          byte (4-byte frames). When undefined, frames are
//                          3 bytes long and the CHK state does not exist.
//
// Parameters:
//   REFRESH_CYCLES - clock cycles between forced periodic frames (>= 2).
//
// Ports:
//   clk             in   system clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   game_state[1:0] in   local game FSM state (0 MENU, 1 GAME, 2 END_SCREEN)
//   game_start      in   local start request (level)
//   current_health  in   local player HP [3:0]
//   boss_hp         in   boss HP [6:0]
//   tx_data[7:0]    out  byte offered to the transmitter
//   tx_valid        out  tx_data is valid
//   tx_ready        in   transmitter accepts the byte this cycle
//   frame_busy      out  high while a frame is in progress (state != IDLE)
//   frame_done      out  one-cycle pulse after the last byte is accepted
// -----------------------------------------------------------------------------
module game_link_tx #(
    parameter int unsigned REFRESH_CYCLES = 1_083_333
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] game_state,
    input  logic       game_start,
    input  logic [3:0] current_health,
    input  logic [6:0] boss_hp,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       frame_busy,
    output logic       frame_done
);

    localparam int unsigned           CNT_W    = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]            HEADER   = 8'hA5;

`ifdef GAME_LINK_CHKSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, STAT, BOSS, CHK} state_t;
`else
    typedef enum logic [1:0] {IDLE, HDR, STAT, BOSS} state_t;
`endif

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [13:0]       snap_q, snap_d;
    logic              frame_done_q, frame_done_d;

    logic [13:0]       live;
    logic              load;
    logic              change_trig;
    logic              refresh_trig;
    logic [CNT_W-1:0]  cnt_inc;
    logic [7:0]        byte1;
    logic [7:0]        byte2;

    // Live status packed in the same order as the snapshot:
    // [13:12] game_state, [11] game_start, [10:7] health, [6:0] boss_hp.
    assign live  = {game_state, game_start, current_health, boss_hp};
    assign byte1 = {1'b0, snap_q[13:7]};
    assign byte2 = {1'b0, snap_q[6:0]};

    // A frame starts (and the snapshot is taken) when IDLE sees pend.
    assign load = (state_q == IDLE) && pend_q;

    // In the load cycle the live inputs are exactly what is being captured,
    // so they do not count as a change against the old snapshot; otherwise
    // every change-triggered frame would be followed by a duplicate.
    assign change_trig = (live != snap_q) && !load;

    // The counter wraps at the increment that would make it REFRESH_CYCLES-1.
    // Raising the trigger on that increment absorbs the one-cycle pend
    // register delay, so forced frames start exactly REFRESH_CYCLES apart.
    assign cnt_inc      = cnt_q + CNT_ONE;
    assign refresh_trig = (cnt_inc == CNT_LAST);

    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path through the case statement can leave one unassigned (latch).
        state_d      = state_q;
        tx_valid     = 1'b0;
        tx_data      = 8'h00;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pend_q) state_d = HDR;
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) state_d = STAT;
            end
            STAT: begin
                tx_valid = 1'b1;
                tx_data  = byte1;
                if (tx_ready) state_d = BOSS;
            end
            BOSS: begin
                tx_valid = 1'b1;
                tx_data  = byte2;
                if (tx_ready) begin
`ifdef GAME_LINK_CHKSUM_EN
                    state_d = CHK;
`else
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
`endif
                end
            end
`ifdef GAME_LINK_CHKSUM_EN
            CHK: begin
                tx_valid = 1'b1;
                tx_data  = HEADER ^ byte1 ^ byte2;
                if (tx_ready) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // A trigger in the load cycle wins over the clear, so it yields one
        // more frame after the one being started.
        pend_d = pend_q;
        if (change_trig || refresh_trig) pend_d = 1'b1;
        else if (load)                   pend_d = 1'b0;

        cnt_d  = (load || refresh_trig) ? '0 : cnt_inc;
        snap_d = load ? live : snap_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_q       <= 1'b1;
            cnt_q        <= '0;
            // NOTE: the snapshot is reset to zero on purpose: it doubles as
            // the "last sent" reference for change detection.
            snap_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update from the same pre-edge values.
            state_q      <= state_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            snap_q       <= snap_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_busy = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_game_link_tx.sv
// -----------------------------------------------------------------------------
// tb_game_link_tx
//
// Directed bench for game_link_tx. Two instances share all inputs: "dut" with a
// long refresh period for the functional scenarios, and "dut_r" with
// REFRESH_CYCLES=16 for the periodic refresh scenario. Outputs are sampled on
// the falling clock edge; inputs are driven there as well.
// -----------------------------------------------------------------------------
module tb_game_link_tx;

`ifdef GAME_LINK_CHKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] game_state;
    logic       game_start;
    logic [3:0] current_health;
    logic [6:0] boss_hp;
    logic       tx_ready;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       frame_busy;
    logic       frame_done;

    logic [7:0] r_tx_data;
    logic       r_tx_valid;
    logic       r_frame_busy;
    logic       r_frame_done;

    int errors = 0;
    int checks = 0;

    game_link_tx #(.REFRESH_CYCLES(1000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .game_state     (game_state),
        .game_start     (game_start),
        .current_health (current_health),
        .boss_hp        (boss_hp),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .frame_busy     (frame_busy),
        .frame_done     (frame_done)
    );

    game_link_tx #(.REFRESH_CYCLES(16)) dut_r (
        .clk            (clk),
        .rst_n          (rst_n),
        .game_state     (game_state),
        .game_start     (game_start),
        .current_health (current_health),
        .boss_hp        (boss_hp),
        .tx_data        (r_tx_data),
        .tx_valid       (r_tx_valid),
        .tx_ready       (tx_ready),
        .frame_busy     (r_frame_busy),
        .frame_done     (r_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected checksum byte: header XOR byte1 XOR byte2.
    function automatic logic [7:0] model_chk(input logic [7:0] b1, input logic [7:0] b2);
        return 8'hA5 ^ b1 ^ b2;
    endfunction

    // Hold reset for two cycles, release on a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] exp [4];
        int n_done;
        int n_valid;
        exp = '{8'hA5, 8'h05, 8'h64, 8'hC4};
        game_state = 2'd0; game_start = 1'b0; current_health = 4'd5; boss_hp = 7'd100;
        tx_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", tx_data); end
        checks++; if (frame_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", frame_busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", frame_done); end
        rst_n = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL release_valid_early got=%b want=0", tx_valid); end
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp[i] || frame_busy !== 1'b1 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL first_frame_byte%0d got v=%b d=%h busy=%b done=%b want v=1 d=%h busy=1 done=0",
                         i, tx_valid, tx_data, frame_busy, frame_done, exp[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || frame_busy !== 1'b0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL first_frame_end got v=%b busy=%b done=%b want v=0 busy=0 done=1",
                     tx_valid, frame_busy, frame_done);
        end
        n_done = 0; n_valid = 0;
        repeat (20) begin
            @(negedge clk);
            if (frame_done === 1'b1) n_done++;
            if (tx_valid === 1'b1) n_valid++;
        end
        checks++; if (n_done !== 0) begin errors++; $display("FAIL extra_done_pulses got=%0d want=0", n_done); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL idle_valid_cycles got=%0d want=0", n_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [4];
        exp = '{8'hA5, 8'h05, 8'h64, 8'hC4};
        tx_ready = 1'b1;
        do_reset();
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("FAIL bp_hdr got v=%b d=%h want v=1 d=a5", tx_valid, tx_data); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h05) begin errors++; $display("FAIL bp_stat got v=%b d=%h want v=1 d=05", tx_valid, tx_data); end
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h05) begin
                errors++;
                $display("FAIL bp_hold%0d got v=%b d=%h want v=1 d=05", i, tx_valid, tx_data);
            end
        end
        tx_ready = 1'b1;
        for (int i = 2; i < NB; i++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
                errors++;
                $display("FAIL bp_byte%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp[i]);
            end
        end
        @(negedge clk);
        checks++; if (frame_done !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL bp_done got done=%b v=%b want done=1 v=0", frame_done, tx_valid); end
    endtask

    task automatic test_mid_frame_change();
        logic [7:0] exp1 [4];
        logic [7:0] exp2 [4];
        int n_valid;
        exp1 = '{8'hA5, 8'h05, 8'h64, 8'hC4};
        exp2 = '{8'hA5, 8'h03, 8'h64, 8'hC2};
        current_health = 4'd5;
        tx_ready = 1'b1;
        do_reset();
        @(negedge clk);
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL mid_hdr got=%h want=a5", tx_data); end
        @(negedge clk);
        checks++; if (tx_data !== 8'h05) begin errors++; $display("FAIL mid_stat got=%h want=05", tx_data); end
        current_health = 4'd3;
        for (int i = 2; i < NB; i++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp1[i]) begin
                errors++;
                $display("FAIL mid_f1_byte%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp1[i]);
            end
        end
        @(negedge clk);
        checks++; if (frame_done !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL mid_f1_done got done=%b v=%b want done=1 v=0", frame_done, tx_valid); end
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp2[i]) begin
                errors++;
                $display("FAIL mid_f2_byte%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp2[i]);
            end
        end
        @(negedge clk);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL mid_f2_done got=%b want=1", frame_done); end
        n_valid = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx_valid === 1'b1) n_valid++;
        end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL mid_third_frame valid_cycles got=%0d want=0", n_valid); end
    endtask

    task automatic test_patterns();
        logic [1:0] v_gs    [3];
        logic       v_start [3];
        logic [3:0] v_hp    [3];
        logic [6:0] v_boss  [3];
        logic [7:0] v_b1    [3];
        logic [7:0] v_b2    [3];
        logic [7:0] exp     [4];
        v_gs    = '{2'd2, 2'd1, 2'd1};
        v_start = '{1'b1, 1'b0, 1'b1};
        v_hp    = '{4'hF, 4'hA, 4'h0};
        v_boss  = '{7'h7F, 7'h00, 7'h01};
        v_b1    = '{8'h5F, 8'h2A, 8'h30};
        v_b2    = '{8'h7F, 8'h00, 8'h01};
        tx_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            game_state = v_gs[p]; game_start = v_start[p];
            current_health = v_hp[p]; boss_hp = v_boss[p];
            exp = '{8'hA5, v_b1[p], v_b2[p], model_chk(v_b1[p], v_b2[p])};
            @(negedge clk);
            checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL pat%0d_latency got v=%b want=0", p, tx_valid); end
            for (int i = 0; i < NB; i++) begin
                @(negedge clk);
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
                    errors++;
                    $display("FAIL pat%0d_byte%0d got v=%b d=%h want v=1 d=%h", p, i, tx_valid, tx_data, exp[i]);
                end
            end
            @(negedge clk);
            checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL pat%0d_done got=%b want=1", p, frame_done); end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_boss();
        logic [7:0] exp [4];
        exp = '{8'hA5, 8'h05, 8'h64, 8'hC4};
        game_state = 2'd0; game_start = 1'b0; current_health = 4'd5; boss_hp = 7'd100;
        tx_ready = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h64) begin errors++; $display("FAIL rb_boss got v=%b d=%h want v=1 d=64", tx_valid, tx_data); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || frame_busy !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL rb_async got v=%b busy=%b d=%h want v=0 busy=0 d=00", tx_valid, frame_busy, tx_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
                errors++;
                $display("FAIL rb_byte%0d got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, exp[i]);
            end
        end
        @(negedge clk);
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL rb_done got=%b want=1", frame_done); end
    endtask

    task automatic test_refresh();
        int starts [$];
        logic prev;
        tx_ready = 1'b1;
        do_reset();
        prev = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (r_frame_busy === 1'b1 && prev === 1'b0) starts.push_back(cyc);
            prev = r_frame_busy;
        end
        checks++; if (starts.size() !== 4) begin errors++; $display("FAIL refresh_count got=%0d want=4", starts.size()); end
        for (int k = 0; k < starts.size() && k < 4; k++) begin
            checks++;
            if (starts[k] !== 16 * k) begin
                errors++;
                $display("FAIL refresh_start%0d got=%0d want=%0d", k, starts[k], 16 * k);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tx_ready = 1'b1;
        game_state = 2'd0; game_start = 1'b0; current_health = 4'd5; boss_hp = 7'd100;
        test_reset();
        test_backpressure();
        test_mid_frame_change();
        test_patterns();
        test_reset_mid_boss();
        test_refresh();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
